// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, drives the imem req/ack port
// and registers {pc, inst, valid} toward IF/ID.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        branch_i,
    input  logic [31:0] branch_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_inst_o,
    output logic        if_valid_o
);

    typedef enum logic [1:0] {
        REQ,
        HOLD,
        DRAIN
    } state_t;

    state_t      state, state_n;
    logic [31:0] fetch_pc, fetch_pc_n;
    logic [31:0] redirect_pc, redirect_pc_n;
    logic [31:0] hold_pc, hold_pc_n;
    logic [31:0] hold_inst, hold_inst_n;
    logic [31:0] pc_n, inst_n;
    logic        valid_n;
    logic [31:0] target;
    logic [31:0] pc_inc;

    assign target      = {branch_target_i[31:2], 2'b00};
    assign pc_inc      = fetch_pc + 32'd4;
    assign imem_req_o  = (state != HOLD);
    assign imem_addr_o = fetch_pc;

    always_comb begin
        state_n       = state;
        fetch_pc_n    = fetch_pc;
        redirect_pc_n = redirect_pc;
        hold_pc_n     = hold_pc;
        hold_inst_n   = hold_inst;
        pc_n          = if_pc_o;
        inst_n        = if_inst_o;
        valid_n       = if_valid_o;
        unique case (state)
            REQ: begin
                if (branch_i) begin
                    valid_n = 1'b0;
                    pc_n    = 32'd0;
                    inst_n  = 32'd0;
                    if (imem_ack_i) begin
                        fetch_pc_n = target;
                    end else begin
                        // request is in flight: finish it before redirecting
                        redirect_pc_n = target;
                        state_n       = DRAIN;
                    end
                end else if (imem_ack_i) begin
                    fetch_pc_n = pc_inc;
                    if (stall_i) begin
                        hold_pc_n   = fetch_pc;
                        hold_inst_n = imem_rdata_i;
                        state_n     = HOLD;
                    end else begin
                        valid_n = 1'b1;
                        pc_n    = fetch_pc;
                        inst_n  = imem_rdata_i;
                    end
                end else if (!stall_i) begin
                    valid_n = 1'b0;
                    pc_n    = 32'd0;
                    inst_n  = 32'd0;
                end
            end
            HOLD: begin
                if (branch_i) begin
                    valid_n    = 1'b0;
                    pc_n       = 32'd0;
                    inst_n     = 32'd0;
                    fetch_pc_n = target;
                    state_n    = REQ;
                end else if (!stall_i) begin
                    valid_n = 1'b1;
                    pc_n    = hold_pc;
                    inst_n  = hold_inst;
                    state_n = REQ;
                end
            end
            DRAIN: begin
                valid_n = 1'b0;
                pc_n    = 32'd0;
                inst_n  = 32'd0;
                if (branch_i) begin
                    redirect_pc_n = target;
                end
                if (imem_ack_i) begin
                    fetch_pc_n = branch_i ? target : redirect_pc;
                    state_n    = REQ;
                end
            end
            default: begin
                state_n = REQ;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= REQ;
            fetch_pc    <= RESET_PC;
            redirect_pc <= 32'd0;
            hold_pc     <= 32'd0;
            hold_inst   <= 32'd0;
            if_pc_o     <= 32'd0;
            if_inst_o   <= 32'd0;
            if_valid_o  <= 1'b0;
        end else begin
            state       <= state_n;
            fetch_pc    <= fetch_pc_n;
            redirect_pc <= redirect_pc_n;
            hold_pc     <= hold_pc_n;
            hold_inst   <= hold_inst_n;
            if_pc_o     <= pc_n;
            if_inst_o   <= inst_n;
            if_valid_o  <= valid_n;
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Scoreboard bench for if_fetch: directed scenarios then random
// stall/branch/ack traffic against a transaction-level stream model.
module tb_if_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_i = 1'b0;
    logic        branch_i = 1'b0;
    logic [31:0] branch_target_i = 32'd0;
    logic        imem_ack_i = 1'b0;
    logic [31:0] imem_rdata_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_inst_o;
    logic        if_valid_o;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } item_t;

    item_t q[$];

    if_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall_i        (stall_i),
        .branch_i       (branch_i),
        .branch_target_i(branch_target_i),
        .imem_req_o     (imem_req_o),
        .imem_addr_o    (imem_addr_o),
        .imem_ack_i     (imem_ack_i),
        .imem_rdata_i   (imem_rdata_i),
        .if_pc_o        (if_pc_o),
        .if_inst_o      (if_inst_o),
        .if_valid_o     (if_valid_o)
    );

    always #5 clk = ~clk;

    // memory contents are a fixed function of the address
    assign imem_rdata_i = imem_addr_o ^ 32'hA5A5_0000;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic r, input logic s, input logic b,
                       input logic [31:0] t, input logic a);
        @(negedge clk);
        #1;
        rst             = r;
        stall_i         = s;
        branch_i        = b;
        branch_target_i = t;
        imem_ack_i      = a;
    endtask

    // Stream model, evaluated just before each rising edge.
    // A branch kills everything fetched but not yet delivered,
    // including a transfer in flight.
    initial begin
        logic        pend;
        logic [31:0] pend_addr;
        logic        taint;
        logic [31:0] exp_addr;
        pend      = 1'b0;
        pend_addr = 32'd0;
        taint     = 1'b0;
        exp_addr  = RESET_PC;
        forever begin
            @(negedge clk);
            #4;
            if (rst) begin
                q.delete();
                taint    = 1'b0;
                exp_addr = RESET_PC;
                pend     = 1'b0;
            end else begin
                chk("req_when_empty", {31'd0, imem_req_o},
                    {31'd0, q.size() == 0});
                if (pend) chk("addr_stable", imem_addr_o, pend_addr);
                if (imem_req_o && imem_ack_i) begin
                    if (!taint && !branch_i) begin
                        chk("fetch_addr", imem_addr_o, exp_addr);
                        q.push_back('{exp_addr, exp_addr ^ 32'hA5A5_0000});
                        exp_addr = exp_addr + 32'd4;
                    end
                    taint = 1'b0;
                end
                if (branch_i) begin
                    q.delete();
                    exp_addr = {branch_target_i[31:2], 2'b00};
                    if (imem_req_o && !imem_ack_i) taint = 1'b1;
                end
                pend      = imem_req_o && !imem_ack_i;
                pend_addr = imem_addr_o;
            end
        end
    end

    // Output monitor, evaluated just after each rising edge.
    initial begin
        item_t       it;
        logic [31:0] lpc;
        logic [31:0] linst;
        logic        lv;
        lpc   = 32'd0;
        linst = 32'd0;
        lv    = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                chk("rst_valid", {31'd0, if_valid_o}, 32'd0);
                chk("rst_pc", if_pc_o, 32'd0);
                chk("rst_inst", if_inst_o, 32'd0);
                chk("rst_req", {31'd0, imem_req_o}, 32'd1);
                chk("rst_addr", imem_addr_o, RESET_PC);
            end else if (branch_i) begin
                chk("br_valid", {31'd0, if_valid_o}, 32'd0);
                chk("br_pc", if_pc_o, 32'd0);
                chk("br_inst", if_inst_o, 32'd0);
            end else if (stall_i) begin
                chk("frz_valid", {31'd0, if_valid_o}, {31'd0, lv});
                chk("frz_pc", if_pc_o, lpc);
                chk("frz_inst", if_inst_o, linst);
            end else if (if_valid_o) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL spurious actual=valid pc %h expected=no delivery",
                             if_pc_o);
                end else begin
                    it = q.pop_front();
                    chk("out_pc", if_pc_o, it.pc);
                    chk("out_inst", if_inst_o, it.inst);
                end
            end else begin
                chk("missing", q.size(), 32'd0);
                chk("bub_pc", if_pc_o, 32'd0);
                chk("bub_inst", if_inst_o, 32'd0);
            end
            lpc   = if_pc_o;
            linst = if_inst_o;
            lv    = if_valid_o;
        end
    end

    initial begin
        cyc(1, 0, 0, 32'd0, 0);
        cyc(1, 0, 0, 32'd0, 0);
        // streaming, then a 3-cycle stall on the ack of 0x8
        cyc(0, 0, 0, 32'd0, 1);
        cyc(0, 0, 0, 32'd0, 1);
        cyc(0, 1, 0, 32'd0, 1);
        cyc(0, 1, 0, 32'd0, 1);
        cyc(0, 1, 0, 32'd0, 1);
        cyc(0, 0, 0, 32'd0, 1);
        cyc(0, 0, 0, 32'd0, 1);
        // branch with ack at 0x10
        cyc(0, 0, 1, 32'h0000_0103, 1);
        cyc(0, 0, 0, 32'd0, 1);
        cyc(0, 0, 1, 32'h0000_0020, 1);
        // branch while 0x20 is outstanding, then a newer one
        cyc(0, 0, 0, 32'd0, 0);
        cyc(0, 0, 1, 32'h0000_0200, 0);
        cyc(0, 0, 0, 32'd0, 0);
        cyc(0, 0, 1, 32'h0000_0300, 0);
        cyc(0, 0, 0, 32'd0, 1);
        cyc(0, 0, 0, 32'd0, 1);
        // wrap at the top of the address space
        cyc(0, 0, 1, 32'hFFFF_FFFE, 1);
        cyc(0, 0, 0, 32'd0, 1);
        cyc(0, 0, 0, 32'd0, 1);
        cyc(0, 0, 0, 32'd0, 1);
        // reset while holding valid output
        cyc(0, 1, 0, 32'd0, 1);
        cyc(1, 0, 0, 32'd0, 1);
        cyc(0, 0, 0, 32'd0, 1);
        cyc(0, 0, 0, 32'd0, 1);
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] t;
            t = ($urandom_range(0, 7) == 0) ?
                (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
            cyc($urandom_range(0, 199) == 0,
                $urandom_range(0, 9) < 3,
                $urandom_range(0, 9) == 0,
                t,
                $urandom_range(0, 9) < 6);
        end
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 32'd0, 1);
        @(posedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage of the Simple-MIPS pipeline. It is the producer side of the IF/ID interface. It owns the program counter and issues one-at-a-time requests to instruction memory over a req/ack handshake. It registers the fetched {pc, inst, valid} for the IF/ID pipeline register. It also absorbs downstream stalls and branch redirects, and never breaks a memory transfer that is already in flight.

## Interface
- RESET_PC, 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- stall_i  in  1  downstream cannot accept; freezes IF outputs.
- branch_i  in  1  redirect request, one-cycle pulse; has priority over stall_i.
- branch_target_i  in  32  redirect address; bits [1:0] are ignored and forced to 0.
- imem_req_o  out  1  memory request.
- imem_addr_o  out  32  request address; equals fetch_pc.
- imem_ack_i  in  1  transfer completes on a rising edge where req && ack.
- imem_rdata_i  in  32  instruction; valid in the ack cycle.
- if_pc_o  out  32  registered PC of the delivered instruction.
- if_inst_o  out  32  registered instruction; 0 (NOP) when invalid.
- if_valid_o  out  1  registered valid.

## Operation
- Registers:
  - fetch_pc: address of the current or next request.
  - redirect_pc: pending target used during DRAIN.
  - hold_pc, hold_inst: skid buffer.
  - FSM state.
- States: REQ, HOLD, DRAIN.
- Handshake rule: while imem_req_o=1 and no ack, imem_addr_o must stay stable. An outstanding request is never withdrawn or re-addressed.
- REQ: imem_req_o=1.
  - branch_i && ack: discard rdata; fetch_pc<=target; stay in REQ.
  - branch_i && !ack: redirect_pc<=target; go to DRAIN.
  - ack && !stall_i: outputs<={1, fetch_pc, rdata}; fetch_pc<=fetch_pc+4.
  - ack && stall_i: hold_pc/hold_inst<=fetch_pc/rdata; fetch_pc<=fetch_pc+4; go to HOLD.
  - !ack: if !stall_i, output a bubble (valid=0, inst=0, pc=0); if stall_i, outputs hold.
- HOLD: imem_req_o=0.
  - branch_i: drop the held data; fetch_pc<=target; go to REQ.
  - !stall_i: outputs<={1, hold_pc, hold_inst}; go to REQ.
  - Otherwise: hold.
- DRAIN: imem_req_o=1 at the old fetch_pc; no outputs are produced.
  - Further branch_i: redirect_pc<=newest target.
  - On ack: discard rdata; fetch_pc<=redirect_pc, or the new target if branch_i is high in the same cycle; go to REQ.
- Any branch_i: outputs<=bubble in that same edge, regardless of stall_i.
- Arithmetic: fetch_pc+4 is modulo 2^32, so 0xFFFF_FFFC wraps to 0x0000_0000.

## Timing
- Reset values:
  - fetch_pc=RESET_PC, state=REQ.
  - if_valid_o=0, if_pc_o=0, if_inst_o=0.
  - imem_req_o goes to 1 combinationally in the first cycle after reset.
- rst asserted in any state, including mid-transfer or HOLD, returns all state to the reset values on that edge. Any in-flight ack is ignored.
- Latency: ack at edge N puts the instruction on if_*_o after edge N.
- Zero-wait memory (ack tied high): one instruction per cycle; addresses RESET_PC, +4, +8, ...
- Stall release from HOLD: the held instruction appears after the release edge. The next request starts in the cycle after that.
- Branch: the target address appears on imem_addr_o in the cycle after the branch edge (REQ or HOLD). From DRAIN, it appears in the cycle after the draining ack.
- Simultaneous events: branch_i beats stall_i, and beats ack delivery.

## Test plan
- Reset, then ack=1 constantly, rdata=addr^0xA5A5_0000:
  - imem_addr_o sequence is 0, 4, 8.
  - Cycle after the first ack: if_pc_o=0, if_inst_o=0xA5A5_0000, valid=1.
- stall_i high for 3 cycles, coinciding with the ack of 0x8:
  - Outputs stay at pc 0x4 and req drops to 0.
  - On release, outputs show pc 0x8, then req resumes at 0xC.
- branch_i with ack at fetch_pc 0x10, target 0x103:
  - Next outputs: valid=0, inst=0.
  - Next imem_addr_o=0x100; data for 0x10 is never delivered.
- ack held low at 0x20, branch_i to 0x200, then branch_i to 0x300 two cycles later:
  - imem_addr_o stays 0x20 until ack, and that data is discarded.
  - Next request is 0x300.
- RESET_PC=0xFFFF_FFFC with ack=1: address sequence is 0xFFFF_FFFC, then 0x0.
- rst asserted while in HOLD with valid=1:
  - Next edge: if_valid_o=0, if_pc_o=0, if_inst_o=0, imem_addr_o=RESET_PC.
